// File: rtl/alu_pkg.sv
// Shared types and constants for the handshaked ALU with iterative multiply/divide.
package alu_pkg;

    localparam int unsigned DEF_XLEN = 32;
    localparam int unsigned ITER_W   = $clog2(DEF_XLEN) + 1;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_SLT   = 4'd4,
        OP_SLTU  = 4'd5,
        OP_XOR   = 4'd6,
        OP_SLL   = 4'd7,
        OP_SRL   = 4'd8,
        OP_SRA   = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIVU  = 4'd12,
        OP_REMU  = 4'd13
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // Divide by zero: quotient is this bit replicated (all ones), remainder is the dividend.
    localparam logic DIVZ_QUO_FILL = 1'b1;
    localparam bit   DIVZ_REM_IS_A = 1'b1;

    function automatic logic is_mdu_op(alu_op_e op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Operation request / result handshake bundle between issue and writeback.
interface alu_mdu_if #(parameter int unsigned XLEN = 32);

    logic                in_valid;
    logic                in_ready;
    alu_pkg::alu_op_e    op;
    logic [XLEN-1:0]     a;
    logic [XLEN-1:0]     b;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     result;
    logic                N;
    logic                Z;
    logic                C;
    logic                V;
    logic                busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, N, Z, C, V, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, N, Z, C, V, busy
    );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative unsigned multiply (shift-add) / divide (restoring), one step per cycle.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = DEF_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            step_i,
    input  alu_op_e         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_c,
    output logic [XLEN-1:0] result_c
);

    localparam int unsigned IW = $clog2(XLEN) + 1;

    logic [IW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            div_q, div_d;
    logic            sel_hi_q, sel_hi_d;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            no_borrow;

    // One datapath step; hi holds partial product / partial remainder, lo holds multiplier / quotient.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        shifted   = {hi_q, lo_q[XLEN-1]};
        diff      = shifted[XLEN-1:0] - b_q;
        no_borrow = (shifted >= {1'b0, b_q});
    end

    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        a_d      = a_q;
        b_d      = b_q;
        div_d    = div_q;
        sel_hi_d = sel_hi_q;
        if (start_i) begin
            cnt_d    = '0;
            hi_d     = '0;
            lo_d     = a_i;
            a_d      = a_i;
            b_d      = b_i;
            div_d    = (op_i == OP_DIVU) || (op_i == OP_REMU);
            sel_hi_d = (op_i == OP_MULHU) || (op_i == OP_REMU);
        end else if (step_i) begin
            cnt_d = cnt_q + IW'(1);
            if (div_q) begin
                hi_d = no_borrow ? diff : shifted[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], no_borrow};
            end else begin
                hi_d = mul_sum[XLEN:1];
                lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            div_q    <= 1'b0;
            sel_hi_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            a_q      <= a_d;
            b_q      <= b_d;
            div_q    <= div_d;
            sel_hi_q <= sel_hi_d;
        end
    end

    // Final step's value is presented combinationally so the owner can register it on the same edge.
    always_comb begin
        done_c = step_i && (cnt_q == IW'(XLEN - 1));
        if (div_q && (b_q == '0)) begin
            result_c = (sel_hi_q && DIVZ_REM_IS_A) ? a_q : {XLEN{DIVZ_QUO_FILL}};
        end else begin
            result_c = sel_hi_q ? hi_d : lo_d;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Handshaked RV32I ALU with flags; MUL/MULHU/DIVU/REMU run on the iterative unit.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = DEF_XLEN
) (
    input  logic      clk,
    input  logic      rst,
    alu_mdu_if.slave  bus
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned MSB = XLEN - 1;

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic [XLEN:0]   add_c, sub_c;
    logic [SHW-1:0]  shamt_c;
    logic [XLEN-1:0] alu_res_c;
    logic            alu_cf_c, alu_vf_c;
    logic            start_c, calc_c, mdu_done_c;
    logic [XLEN-1:0] mdu_res_c;

    // Single-cycle ops and their carry/overflow flags.
    always_comb begin
        add_c     = {1'b0, bus.a} + {1'b0, bus.b};
        sub_c     = {1'b0, bus.a} + {1'b0, ~bus.b} + (XLEN+1)'(1);
        shamt_c   = bus.b[SHW-1:0];
        alu_res_c = '0;
        alu_cf_c  = 1'b0;
        alu_vf_c  = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_res_c = add_c[XLEN-1:0];
                alu_cf_c  = add_c[XLEN];
                alu_vf_c  = (bus.a[MSB] == bus.b[MSB]) && (add_c[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                alu_res_c = sub_c[XLEN-1:0];
                alu_cf_c  = sub_c[XLEN];
                alu_vf_c  = (bus.a[MSB] != bus.b[MSB]) && (sub_c[MSB] != bus.a[MSB]);
            end
            OP_AND:  alu_res_c = bus.a & bus.b;
            OP_OR:   alu_res_c = bus.a | bus.b;
            OP_XOR:  alu_res_c = bus.a ^ bus.b;
            OP_SLT:  alu_res_c = XLEN'($signed(bus.a) < $signed(bus.b));
            OP_SLTU: alu_res_c = XLEN'(bus.a < bus.b);
            OP_SLL:  alu_res_c = bus.a << shamt_c;
            OP_SRL:  alu_res_c = bus.a >> shamt_c;
            OP_SRA:  alu_res_c = $unsigned($signed(bus.a) >>> shamt_c);
            default: alu_res_c = '0;
        endcase
    end

    alu_muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_c),
        .step_i   (calc_c),
        .op_i     (bus.op),
        .a_i      (bus.a),
        .b_i      (bus.b),
        .done_c   (mdu_done_c),
        .result_c (mdu_res_c)
    );

    assign calc_c = (state_q == CALC);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        n_d      = n_q;
        z_d      = z_q;
        c_d      = c_q;
        v_d      = v_q;
        start_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (is_mdu_op(bus.op)) begin
                        state_d = CALC;
                        start_c = 1'b1;
                    end else begin
                        state_d  = DONE;
                        result_d = alu_res_c;
                        n_d      = alu_res_c[MSB];
                        z_d      = (alu_res_c == '0);
                        c_d      = alu_cf_c;
                        v_d      = alu_vf_c;
                    end
                end
            end
            CALC: begin
                if (mdu_done_c) begin
                    state_d  = DONE;
                    result_d = mdu_res_c;
                    n_d      = mdu_res_c[MSB];
                    z_d      = (mdu_res_c == '0);
                    c_d      = 1'b0;
                    v_d      = 1'b0;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == CALC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            n_q         <= n_d;
            z_q         <= z_d;
            c_q         <= c_d;
            v_q         <= v_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;
    assign bus.N         = n_q;
    assign bus.Z         = z_q;
    assign bus.C         = c_q;
    assign bus.V         = v_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: expected results queued at issue, popped when out_valid is seen.
module tb_alu_mdu;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  nzcv;
    } exp_t;

    typedef struct {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  nzcv;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_mdu_if #(.XLEN(32)) bus ();

    alu_mdu #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [3:0] flags();
        return {bus.N, bus.Z, bus.C, bus.V};
    endfunction

    // Present one operation at a negedge and hold it until it is accepted; returns at the next negedge.
    task automatic issue(input alu_op_e op, input logic [31:0] a, input logic [31:0] b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) return;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.op       = alu_op_e'(4'($urandom_range(0, 15)));
    endtask

    // Count sampled cycles after accept until out_valid; lat==1 is the first cycle after accept.
    task automatic wait_out(output int lat, output int busy_cnt, output bit rdy_seen, output bit ok);
        lat = 1; busy_cnt = 0; rdy_seen = 1'b0; ok = 1'b0;
        while (lat < 200) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: rdy/ov/busy got %b%b%b want 100", bus.in_ready, bus.out_valid, bus.busy);
        end
        checks++;
        if (bus.result !== 32'h0 || flags() !== 4'b0000) begin
            errors++;
            $display("FAIL reset_data: result %h nzcv %b want 0 0000", bus.result, flags());
        end
    endtask

    task automatic test_alu();
        vec_t v[14] = '{
            '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001},
            '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110},
            '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 4'b0110},
            '{OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000},
            '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011},
            '{OP_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 4'b0000},
            '{OP_OR,   32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 4'b0000},
            '{OP_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 4'b1000},
            '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000},
            '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0100},
            '{OP_SLL,  32'h00000001, 32'h0000001F, 32'h80000000, 4'b1000},
            '{OP_SRL,  32'h80000000, 32'h00000024, 32'h08000000, 4'b0000},
            '{OP_SRA,  32'h80000000, 32'h00000021, 32'hC0000000, 4'b1000},
            '{alu_op_e'(4'd14), 32'h5, 32'h5, 32'h00000000, 4'b0100}
        };
        exp_t e;
        int   lat, bcnt;
        bit   rdy, ok;
        foreach (v[i]) begin
            issue(v[i].op, v[i].a, v[i].b, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL alu_accept[%0d]: in_ready never high", i);
                continue;
            end
            sb.push_back('{v[i].res, v[i].nzcv});
            wait_out(lat, bcnt, rdy, ok);
            e = sb.pop_front();
            checks++;
            if (!ok || lat != 1 || rdy) begin
                errors++;
                $display("FAIL alu_latency[%0d]: got %0d cycles (rdy_seen=%b) want 1", i, lat, rdy);
            end
            checks++;
            if (bus.result !== e.res || flags() !== e.nzcv) begin
                errors++;
                $display("FAIL alu_result[%0d]: got %h nzcv %b want %h nzcv %b", i, bus.result, flags(), e.res, e.nzcv);
            end
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL alu_consume[%0d]: ov %b rdy %b want 0 1", i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_mdu();
        vec_t v[12] = '{
            '{OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1000},
            '{OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000},
            '{OP_MUL,   32'd12345,    32'd1000,     32'd12345000, 4'b0000},
            '{OP_MULHU, 32'h00010000, 32'h00010000, 32'h00000001, 4'b0000},
            '{OP_MUL,   32'h00010000, 32'h00010000, 32'h00000000, 4'b0100},
            '{OP_DIVU,  32'd100,      32'd7,        32'd14,       4'b0000},
            '{OP_REMU,  32'd100,      32'd7,        32'd2,        4'b0000},
            '{OP_DIVU,  32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF, 4'b1000},
            '{OP_REMU,  32'h00001234, 32'h00000000, 32'h00001234, 4'b0000},
            '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 4'b1000},
            '{OP_REMU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 4'b0000},
            '{OP_DIVU,  32'd7,        32'd100,      32'd0,        4'b0100}
        };
        exp_t e;
        int   lat, bcnt;
        bit   rdy, ok;
        foreach (v[i]) begin
            issue(v[i].op, v[i].a, v[i].b, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL mdu_accept[%0d]: in_ready never high", i);
                continue;
            end
            sb.push_back('{v[i].res, v[i].nzcv});
            wait_out(lat, bcnt, rdy, ok);
            e = sb.pop_front();
            checks++;
            if (!ok || lat != 33 || bcnt != 32 || rdy) begin
                errors++;
                $display("FAIL mdu_timing[%0d]: lat %0d busy %0d rdy_seen %b want 33 32 0", i, lat, bcnt, rdy);
            end
            checks++;
            if (bus.result !== e.res || flags() !== e.nzcv) begin
                errors++;
                $display("FAIL mdu_result[%0d]: got %h nzcv %b want %h nzcv %b", i, bus.result, flags(), e.res, e.nzcv);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   accepts = 0;
        int   outs = 0;
        bus.in_valid = 1'b1;
        bus.op       = OP_ADD;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) begin
                e = sb.pop_front();
                outs++;
                checks++;
                if (bus.result !== e.res || flags() !== e.nzcv) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got %h nzcv %b want %h nzcv %b", i, bus.result, flags(), e.res, e.nzcv);
                end
            end
            if (bus.in_ready) begin
                bus.a = 32'h100 * (i + 1);
                bus.b = 32'(i + 3);
                sb.push_back('{bus.a + bus.b, 4'b0000});
                accepts++;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (accepts != 4 || outs != 4) begin
            errors++;
            $display("FAIL b2b_rate: accepts %0d outputs %0d in 8 cycles want 4 4", accepts, outs);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat, bcnt;
        bit   rdy, ok, bad;
        bus.out_ready = 1'b0;
        issue(OP_ADD, 32'hFFFFFFFF, 32'h00000001, ok);
        sb.push_back('{32'h0, 4'b0110});
        wait_out(lat, bcnt, rdy, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || bus.result !== e.res || flags() !== e.nzcv) begin
            errors++;
            $display("FAIL bp_first: ok %b got %h nzcv %b want %h nzcv %b", ok, bus.result, flags(), e.res, e.nzcv);
        end
        bus.in_valid = 1'b1;
        bus.op = OP_SUB; bus.a = 32'h1; bus.b = 32'h2;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0 ||
                bus.result !== e.res || flags() !== e.nzcv) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: ov %b rdy %b result %h nzcv %b want 1 0 %h %b", bus.out_valid, bus.in_ready, bus.result, flags(), e.res, e.nzcv);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: ov %b rdy %b want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_calc();
        bit ok, spurious;
        issue(OP_DIVU, 32'd1000, 32'd3, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (!ok || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: accepted %b busy %b want 1 1", ok, bus.busy);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.result !== 32'h0 || flags() !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid: rdy %b ov %b busy %b result %h nzcv %b want 1 0 0 0 0000",
                     bus.in_ready, bus.out_valid, bus.busy, bus.result, flags());
        end
        spurious = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin
            errors++;
            $display("FAIL rst_spurious: activity seen after reset with no request");
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op        = OP_ADD;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_alu();
        test_mdu();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_calc();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expectations left want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
